univ_reg_set: RTL and testbench

Parametrised universal register with synchronous preset: the successor to the single-bit D flip-flop with set. It holds a WIDTH-bit word that can be held, loaded, shifted or rotated under a mode select. It also provides an autonomous MSB-first serialiser sequence (start/busy/done). It sits in datapath and serial-link glue as the common storage/shift element.

---
 rtl/univ_reg_pkg.sv | 19 +
 rtl/univ_reg_set_if.sv | 24 ++
 rtl/univ_reg_set.sv | 77 +++++++
 tb/tb_univ_reg_set.sv | 122 ++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// rtl/univ_reg_pkg.sv - mode and serialiser state encodings for univ_reg_set
package univ_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/univ_reg_set_if.sv
// rtl/univ_reg_set_if.sv - control, data and status bundle of univ_reg_set
interface univ_reg_set_if #(
  parameter int WIDTH = 8
);
  logic             set;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output set, mode, d, sin, start,
    input  q, sout, busy, done
  );

  modport slave (
    input  set, mode, d, sin, start,
    output q, sout, busy, done
  );
endinterface

// File: rtl/univ_reg_set.sv
// rtl/univ_reg_set.sv - universal hold/load/shift/rotate register with preset and MSB-first serialiser
module univ_reg_set
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SET_VALUE = '1
) (
  input  logic          clk,
  input  logic          rst,
  univ_reg_set_if.slave bus
);

  localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] q, q_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q;
    case (state)
      IDLE: begin
        // start takes precedence over whatever mode is presented
        if (bus.start) begin
          q_n     = bus.d;
          cnt_n   = '0;
          state_n = SHIFT;
        end else begin
          case (bus.mode)
            MODE_LOAD: q_n = bus.d;
            MODE_SHL:  q_n = {q[WIDTH-2:0], bus.sin};
            MODE_SHR:  q_n = {bus.sin, q[WIDTH-1:1]};
            MODE_ROL:  q_n = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_n = {q[0], q[WIDTH-1:1]};
            default:   q_n = q;
          endcase
        end
      end
      SHIFT: begin
        q_n = {q[WIDTH-2:0], 1'b0};
        // counter saturates at the last bit instead of wrapping
        if (cnt == LAST) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else if (bus.set) begin
      q     <= SET_VALUE;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      q     <= q_n;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign bus.q    = q;
  assign bus.sout = q[WIDTH-1];
  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_univ_reg_set.sv
// tb/tb_univ_reg_set.sv - directed self-checking bench for univ_reg_set
module tb_univ_reg_set;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  univ_reg_set_if #(.WIDTH(8)) bus ();

  univ_reg_set #(.WIDTH(8), .SET_VALUE(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // one rising edge, then land on the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.set = 1'b1; bus.start = 1'b1;
    bus.mode = 3'b001; bus.d = 8'h77; bus.sin = 1'b1;
    step();
    step();
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", bus.q); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.sout !== 1'b0) begin errors++; $display("FAIL reset_sout got=%b exp=0", bus.sout); end
    rst = 1'b0; bus.set = 1'b0; bus.start = 1'b0;
    bus.mode = 3'b000; bus.d = 8'h00; bus.sin = 1'b0;
  endtask

  task automatic test_modes();
    bus.set = 1'b1; step(); bus.set = 1'b0;
    checks++; if (bus.q !== 8'hFF) begin errors++; $display("FAIL set_q got=%h exp=ff", bus.q); end
    bus.mode = 3'b001; bus.d = 8'h5A; step();
    checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL load_q got=%h exp=5a", bus.q); end
    bus.mode = 3'b100; step();
    checks++; if (bus.q !== 8'hB4) begin errors++; $display("FAIL rol_q got=%h exp=b4", bus.q); end
    bus.mode = 3'b101; step();
    checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL ror_q got=%h exp=5a", bus.q); end
    bus.mode = 3'b010; bus.sin = 1'b1; step();
    checks++; if (bus.q !== 8'hB5) begin errors++; $display("FAIL shl_q got=%h exp=b5", bus.q); end
    bus.mode = 3'b011; bus.sin = 1'b0; step();
    checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL shr_q got=%h exp=5a", bus.q); end
    checks++; if (bus.sout !== 1'b0) begin errors++; $display("FAIL shr_sout got=%b exp=0", bus.sout); end
    bus.mode = 3'b110; bus.d = 8'h00; step();
    checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL reserved_hold_q got=%h exp=5a", bus.q); end
    bus.mode = 3'b000; step();
    checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL hold_q got=%h exp=5a", bus.q); end
  endtask

  // expects start already sampled; checks cycles k+1..k+9 for pattern pat
  task automatic run_serial(input logic [7:0] pat, input bit disturb, input string tag);
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.sout !== pat[7-i]) begin errors++; $display("FAIL %s_sout[%0d] got=%b exp=%b", tag, i, bus.sout, pat[7-i]); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_busy[%0d] got=%b exp=1", tag, i, bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_early[%0d] got=%b exp=0", tag, i, bus.done); end
      if (disturb && i == 2) begin bus.mode = 3'b001; bus.d = 8'h00; bus.start = 1'b1; bus.sin = 1'b1; end
      if (disturb && i == 6) begin bus.mode = 3'b000; bus.start = 1'b0; bus.sin = 1'b0; end
      step();
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL %s_done got=%b exp=1", tag, bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got=%b exp=0", tag, bus.busy); end
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL %s_q_end got=%h exp=00", tag, bus.q); end
  endtask

  task automatic test_serial();
    bus.d = 8'hA5; bus.start = 1'b1; step(); bus.start = 1'b0; bus.d = 8'h00;
    run_serial(8'hA5, 1'b0, "serial");
    step();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL serial_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_abort();
    bus.d = 8'hC3; bus.start = 1'b1; step(); bus.start = 1'b0;
    step(); step(); step();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got=%b exp=1", bus.busy); end
    bus.set = 1'b1; step(); bus.set = 1'b0;
    checks++; if (bus.q !== 8'hFF) begin errors++; $display("FAIL abort_q got=%h exp=ff", bus.q); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_no_done[%0d] got=%b exp=0", i, bus.done); end
      step();
    end
  endtask

  task automatic test_ignored();
    bus.d = 8'hA5; bus.start = 1'b1; step(); bus.start = 1'b0;
    run_serial(8'hA5, 1'b1, "ignored");
    step();
  endtask

  task automatic test_back_to_back();
    bus.d = 8'hA5; bus.start = 1'b1; step(); bus.start = 1'b0;
    run_serial(8'hA5, 1'b0, "b2b_first");
    bus.d = 8'h3C; bus.start = 1'b1; step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done got=%b exp=0", bus.busy); end
    step(); bus.start = 1'b0;
    run_serial(8'h3C, 1'b0, "b2b_second");
    step();
  endtask

  initial begin
    bus.set = 1'b0; bus.mode = 3'b000; bus.d = 8'h00; bus.sin = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    test_reset();
    test_modes();
    test_serial();
    test_abort();
    test_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
